// File: rtl/addsub_pkg_311.sv
// rtl/addsub_pkg_311.sv - shared constants and FSM state encoding for the serial adder/subtractor
package addsub_pkg_311;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell_311.sv
// rtl/fa_cell_311.sv - 1-bit combinational full adder used as the serial datapath
module fa_cell_311 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_311.sv
// rtl/serial_addsub_311.sv - bit-serial add/subtract, LSB first; SERIAL_ADDSUB_OVF_EN adds ovf_311
module serial_addsub_311
    import addsub_pkg_311::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_311,
    input  logic             rst_n_311,
    input  logic             start_311,
    input  logic             sub_311,
    input  logic [WIDTH-1:0] a_311,
    input  logic [WIDTH-1:0] b_311,
    output logic             busy_311,
    output logic             done_311,
    output logic [WIDTH-1:0] sum_311,
    output logic             cout_311
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf_311
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             sub_q;
    logic             carry_q;
    logic             cout_q;
    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;

    // Subtraction is a + ~b + 1: invert B per bit and preload the carry with 1.
    fa_cell_311 u_fa (
        .a    (a_q[0]),
        .b    (b_q[0] ^ sub_q),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_311) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_311 or negedge rst_n_311) begin
        if (!rst_n_311) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_311 or negedge rst_n_311) begin
        if (!rst_n_311) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a_311;
            b_q     <= b_311;
            sub_q   <= sub_311;
            carry_q <= sub_311;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last_bit) begin
                cout_q <= fa_cout;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;

    // During the MSB cycle carry_q is the carry into the MSB.
    always_ff @(posedge clk_311 or negedge rst_n_311) begin
        if (!rst_n_311) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_bit) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign ovf_311 = ovf_q;
`endif

    assign busy_311 = (state_q != IDLE);
    assign done_311 = (state_q == DONE);
    assign sum_311  = sum_q;
    assign cout_311 = cout_q;

endmodule

// File: doc/serial_addsub_311.md
SERIAL_ADDSUB_311 -- requirements
Module: serial_addsub_311

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk_311  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n_311  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_311  input  1  request; sampled only while idle.
REQ-005 SHALL have port sub_311  input  1  0 = a+b, 1 = a-b; sampled with start_311.
REQ-006 SHALL have port a_311  input  WIDTH  operand A; sampled with start_311.
REQ-007 SHALL have port b_311  input  WIDTH  operand B; sampled with start_311.
REQ-008 SHALL have port busy_311  output  1  high while an operation is in flight, including the done cycle.
REQ-009 SHALL have port done_311  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port sum_311  output  WIDTH  result, held stable until the next accepted start.
REQ-011 SHALL have port cout_311  output  1  final carry out; for subtract, 1 = no borrow.

Function
REQ-012 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with busy_311 = (state != IDLE).
REQ-013 SHALL accept start_311 in IDLE only; on acceptance it latches a, b and sub, preloads the carry FF with sub_311, clears the bit counter and enters RUN.
REQ-014 SHALL, in RUN, pass one bit per cycle LSB-first through a single 1-bit full adder: inputs A[i], B[i]^sub and carry FF; the sum bit shifts into the result MSB, and carry-out loads the carry FF.
REQ-015 SHALL leave RUN after exactly WIDTH bit-cycles (counter 0..WIDTH-1) and enter DONE.
REQ-016 SHALL drive done_311 high for exactly one cycle, in DONE, on the (WIDTH+1)th rising edge after the edge that accepted start_311, with sum_311/cout_311 already final.
REQ-017 SHALL ignore start_311 in RUN and DONE; no queuing and no corruption of the in-flight operation.
REQ-018 SHALL accept a start_311 asserted in the IDLE cycle immediately following DONE, for a back-to-back throughput of one result per WIDTH+2 cycles.
REQ-019 SHALL keep sum_311/cout_311 unchanged from done until the next accepted start, after which they are undefined until the next done.
REQ-020 SHALL ignore a_311/b_311/sub_311 changes after acceptance.

Reset
REQ-021 SHALL, on rst_n_311 low at any time (including mid-RUN), immediately force IDLE and clear busy, done, sum, cout, counter, carry FF and operand registers; the in-flight operation is discarded with no done pulse.
REQ-022 SHALL allow a start_311 to be accepted on the first rising edge after rst_n_311 deasserts.

Configuration
REQ-023 SHALL, with macro SERIAL_ADDSUB_OVF_EN defined, add port ovf_311  output  1: signed overflow = carry into MSB XOR carry out of MSB, valid and held per the same rules as cout_311, and reset to 0.
REQ-024 SHALL, without SERIAL_ADDSUB_OVF_EN, omit the ovf_311 port and its logic entirely; all other behaviour is identical.

Structure
REQ-025 SHALL place the FSM state encoding typedef (IDLE/RUN/DONE) and the WIDTH default constant in shared package addsub_pkg_311.
REQ-026 SHALL instantiate exactly one combinational sub-module fa_cell_311 (1-bit full adder: a, b, cin -> s, cout) as the datapath; all sequencing stays in serial_addsub_311.

Verification (WIDTH=8)
REQ-027 SHALL cover add: a=8'h3C, b=8'h05, sub=0 -> sum=8'h41, cout=0, done exactly 9 edges after the accepting edge.
REQ-028 SHALL cover wrap: a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0 (OVF_EN build).
REQ-029 SHALL cover subtract: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; and a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
REQ-030 SHALL cover overflow: a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, ovf=1; and a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, ovf=1.
REQ-031 SHALL cover protocol: start held high through RUN with changing operands -> exactly one done with the first result; the next start is accepted in the IDLE cycle after DONE.
REQ-032 SHALL cover reset: rst_n_311 pulsed low at bit-cycle 4 -> outputs zero at once, no done pulse; a new start after release gives the correct result.
